// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared state encoding and segment constants for the BCD display scanner
package bcd_disp_pkg;

    typedef enum logic [1:0] {SHOW_ONES, DEAD_A, SHOW_TENS, DEAD_B} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} glyphs for digits 0..9
    localparam logic [0:9][6:0] GLYPH = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_display_scanner_seg7.sv
// bcd_to_seg7: nibble to active-low seven-segment pattern, dash for non-BCD nibbles
import bcd_disp_pkg::*;

module bcd_to_seg7 (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = (i_nib > 4'd9) ? SEG_DASH : GLYPH[i_nib];

endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: tear-free two-digit multiplexed seven-segment driver with dead time
import bcd_disp_pkg::*;

module bcd_display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       bcd_err,
    output logic       frame_done
);

    localparam int MAXC = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CW   = $clog2(MAXC);

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_lim;
    logic            w_show, w_adv, w_bnd;
    logic [7:0]      r_shadow, r_disp;
    logic            r_pending, r_bnd;
    logic [3:0]      w_nib;
    logic [6:0]      w_glyph, w_seg;
    logic [1:0]      w_an;

    assign w_show = (r_state == SHOW_ONES) || (r_state == SHOW_TENS);
    assign w_lim  = w_show ? CW'(REFRESH_DIV - 1) : CW'(DEAD_CYCLES - 1);
    assign w_adv  = (r_cnt == w_lim);
    assign w_bnd  = (r_state == DEAD_B) && w_adv;
    assign w_nib  = (r_state == SHOW_TENS) ? r_disp[7:4] : r_disp[3:0];

    bcd_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // Phase sequencing and the segment/anode pattern for the current phase
    always_comb begin
        w_next = r_state;
        w_an   = 2'b11;
        w_seg  = SEG_BLANK;
        case (r_state)
            SHOW_ONES: begin
                w_an  = 2'b10;
                w_seg = w_glyph;
                if (w_adv) w_next = DEAD_A;
            end
            DEAD_A: begin
                if (w_adv) w_next = SHOW_TENS;
            end
            SHOW_TENS: begin
                w_an  = 2'b01;
                w_seg = (blank_lz && r_disp[7:4] == 4'd0) ? SEG_BLANK : w_glyph;
                if (w_adv) w_next = DEAD_B;
            end
            default: begin
                if (w_adv) w_next = SHOW_ONES;
            end
        endcase
    end

    // Phase register and dwell counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SHOW_ONES;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_adv ? '0 : r_cnt + 1'b1;
        end
    end

    // Shadow capture; commit to the displayed value only at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= 8'h00;
            r_pending <= 1'b0;
            r_disp    <= 8'h00;
        end else begin
            if (load) r_shadow <= bcd_in;
            if (w_bnd) begin
                r_pending <= 1'b0;
                if (load) r_disp <= bcd_in;
                else if (r_pending) r_disp <= r_shadow;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Registered outputs, one cycle behind the phase that produced them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            an         <= 2'b11;
            bcd_err    <= 1'b0;
            r_bnd      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg        <= w_seg;
            an         <= w_an;
            bcd_err    <= (r_disp[7:4] > 4'd9) || (r_disp[3:0] > 4'd9);
            r_bnd      <= w_bnd;
            frame_done <= r_bnd;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: scoreboard bench with hand-computed per-cycle display expectations
module tb_bcd_display_scanner;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        logic       err;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bcd_in;
    logic       load;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;
    logic       bcd_err;
    logic       frame_done;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    bcd_display_scanner #(.REFRESH_DIV(4), .DEAD_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .bcd_err    (bcd_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input exp_t e);
        checks++;
        if (an !== e.an || seg !== e.seg || bcd_err !== e.err || frame_done !== e.fd) begin
            failures++;
            $display("FAIL %s t=%0t got an=%b seg=%h err=%b fd=%b want an=%b seg=%h err=%b fd=%b",
                     name, $time, an, seg, bcd_err, frame_done, e.an, e.seg, e.err, e.fd);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [6:0] s, input logic e, input logic f);
        exp_t x;
        x.an = a; x.seg = s; x.err = e; x.fd = f;
        q.push_back(x);
    endtask

    // One frame of 12 cycles (or nc of them): os/ts are the expected ones/tens glyphs
    task automatic frame(input logic [6:0] os, input logic [6:0] ts, input logic err,
                         input logic fd, input logic blz, input int nc,
                         input int p1, input logic [7:0] v1, input int p2, input logic [7:0] v2);
        for (int i = 0; i < nc; i++) begin
            blank_lz = blz;
            load     = (i == p1) || (i == p2);
            bcd_in   = (i == p2) ? v2 : v1;
            if (i < 4)       push(2'b10, os, err, fd && i == 0);
            else if (i < 6)  push(2'b11, 7'h7F, err, 1'b0);
            else if (i < 10) push(2'b01, ts, err, 1'b0);
            else             push(2'b11, 7'h7F, err, 1'b0);
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    // Monitor: one scoreboard entry per clock, sampled just after the active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("scan", e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t r;
        r.an = 2'b11; r.seg = 7'h7F; r.err = 1'b0; r.fd = 1'b0;
        rst = 1'b1; load = 1'b0; bcd_in = 8'h00; blank_lz = 1'b0;
        @(negedge clk);
        repeat (3) begin
            push(2'b11, 7'h7F, 1'b0, 1'b0);
            @(negedge clk);
        end
        rst = 1'b0;
        frame(7'h40, 7'h40, 1'b0, 1'b0, 1'b0, 12, -1, 8'h00, -1, 8'h00);
        frame(7'h40, 7'h40, 1'b0, 1'b1, 1'b0, 12,  1, 8'h25, -1, 8'h00);
        frame(7'h12, 7'h24, 1'b0, 1'b1, 1'b1, 12,  5, 8'h03, -1, 8'h00);
        frame(7'h30, 7'h7F, 1'b0, 1'b1, 1'b1, 12, -1, 8'h00, -1, 8'h00);
        frame(7'h30, 7'h40, 1'b0, 1'b1, 1'b0, 12,  8, 8'h1C, -1, 8'h00);
        frame(7'h3F, 7'h79, 1'b1, 1'b1, 1'b0, 12,  3, 8'h31, -1, 8'h00);
        frame(7'h79, 7'h30, 1'b0, 1'b1, 1'b0, 12,  2, 8'h11, 11, 8'h29);
        frame(7'h10, 7'h24, 1'b0, 1'b1, 1'b0, 12, -1, 8'h00, -1, 8'h00);
        frame(7'h10, 7'h24, 1'b0, 1'b1, 1'b0,  8,  2, 8'h77, -1, 8'h00);
        rst = 1'b1;
        #1;
        cmp("async_reset", r);
        @(negedge clk);
        cmp("reset_hold", r);
        rst = 1'b0;
        frame(7'h40, 7'h40, 1'b0, 1'b0, 1'b0, 12, -1, 8'h00, -1, 8'h00);
        frame(7'h40, 7'h40, 1'b0, 1'b1, 1'b0, 12, -1, 8'h00, -1, 8'h00);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
